// File: rtl/line_pi_ctrl.sv
// rtl/line_pi_ctrl.sv - IR line sensor sequencer with PI steering, forward ramp and motor command outputs
module line_pi_ctrl #(
  parameter int          NUM_PAIRS   = 3,
  parameter int          SETTLE_CYC  = 4095,
  parameter int          GAP_CYC     = 31,
  parameter int          TIMEOUT_CYC = 1023,
  parameter int          INT_DEC     = 4,
  parameter int          FWD_STEP    = 8,
  parameter logic [11:0] FWD_MAX     = 12'h380
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 go,
  output logic                 strt_cnv,
  output logic [2:0]           chnnl,
  input  logic                 cnv_cmplt,
  input  logic [11:0]          A2D_res,
  input  logic [13:0]          Pterm,
  input  logic [11:0]          Iterm,
  output logic [NUM_PAIRS-1:0] IR_en,
  output logic [10:0]          lft,
  output logic [10:0]          rht,
  output logic [7:0]           LEDs,
  output logic                 cycle_done,
  output logic                 a2d_err
);

  typedef enum logic [3:0] {
    IDLE, SETTLE, WAIT_R, GAP, WAIT_L, NEXT, INTG, ICMP, PCMP, MOTOR
  } state_t;

  localparam logic [15:0]          SETTLE_LAST  = 16'(SETTLE_CYC - 1);
  localparam logic [15:0]          GAP_LAST     = 16'(GAP_CYC - 1);
  localparam logic [15:0]          TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [1:0]           LAST_K       = 2'(NUM_PAIRS - 1);
  localparam logic [NUM_PAIRS-1:0] IR_FIRST     = NUM_PAIRS'(1);

  state_t                 state_q;
  logic [15:0]            cnt_q;
  logic [1:0]             k_q;
  logic [NUM_PAIRS-1:0]   ir_en_q;
  logic                   strt_cnv_q;
  logic [2:0]             chnnl_q;
  logic                   cycle_done_q;
  logic                   a2d_err_q;
  // 18 bits holds the full weighted sum even with four pairs at full scale
  logic signed [17:0]     accum_q;
  logic signed [11:0]     error_q;
  logic signed [11:0]     intgrl_q;
  logic signed [15:0]     icomp_q;
  logic signed [15:0]     pcomp_q;
  logic [11:0]            fwd_q;
  logic [7:0]             int_cnt_q;
  logic signed [11:0]     lft_reg_q;
  logic signed [11:0]     rht_reg_q;

  // Clamp helpers; callers sign-extend their operand to 27 bits first
  function automatic logic signed [11:0] sat12(input logic signed [26:0] v);
    if (v > 27'sd2047)       return 12'sh7FF;
    else if (v < -27'sd2048) return 12'sh800;
    else                     return v[11:0];
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [26:0] v);
    if (v > 27'sd32767)       return 16'sh7FFF;
    else if (v < -27'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  logic [17:0]        a2d_sh;
  logic signed [17:0] acc_add;
  logic signed [17:0] acc_sub;
  logic [12:0]        fwd_sum;
  logic [11:0]        fwd_nxt;
  logic [7:0]         int_cnt_inc;
  logic signed [12:0] intg_sum;
  logic signed [24:0] iprod;
  logic signed [24:0] ishift;
  logic signed [26:0] pprod;
  logic signed [26:0] pshift;
  logic signed [17:0] fwd_ext;
  logic signed [17:0] rht_sum;
  logic signed [17:0] lft_sum;

  // Datapath arithmetic feeding the registered state updates
  assign a2d_sh      = {6'b0, A2D_res} << k_q;
  assign acc_add     = accum_q + $signed(a2d_sh);
  assign acc_sub     = accum_q - $signed(a2d_sh);
  assign fwd_sum     = {1'b0, fwd_q} + 13'(FWD_STEP);
  assign fwd_nxt     = (fwd_sum > {1'b0, FWD_MAX}) ? FWD_MAX : fwd_sum[11:0];
  assign int_cnt_inc = int_cnt_q + 8'd1;
  assign intg_sum    = 13'(intgrl_q) + 13'(error_q);
  assign iprod       = 25'(intgrl_q) * 25'($signed({1'b0, Iterm}));
  assign ishift      = iprod >>> 12;
  assign pprod       = 27'(error_q) * 27'($signed({1'b0, Pterm}));
  assign pshift      = pprod >>> 12;
  assign fwd_ext     = $signed({6'b0, fwd_q});
  assign rht_sum     = fwd_ext - 18'(pcomp_q) - 18'(icomp_q);
  assign lft_sum     = fwd_ext + 18'(pcomp_q) + 18'(icomp_q);

  // Sequencer and PI loop; go low wipes all loop state on the next edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      k_q          <= '0;
      ir_en_q      <= '0;
      strt_cnv_q   <= 1'b0;
      chnnl_q      <= '0;
      cycle_done_q <= 1'b0;
      a2d_err_q    <= 1'b0;
      accum_q      <= '0;
      error_q      <= '0;
      intgrl_q     <= '0;
      icomp_q      <= '0;
      pcomp_q      <= '0;
      fwd_q        <= '0;
      int_cnt_q    <= '0;
      lft_reg_q    <= '0;
      rht_reg_q    <= '0;
    end else if (!go) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      k_q          <= '0;
      ir_en_q      <= '0;
      strt_cnv_q   <= 1'b0;
      chnnl_q      <= '0;
      cycle_done_q <= 1'b0;
      a2d_err_q    <= 1'b0;
      accum_q      <= '0;
      error_q      <= '0;
      intgrl_q     <= '0;
      icomp_q      <= '0;
      pcomp_q      <= '0;
      fwd_q        <= '0;
      int_cnt_q    <= '0;
      lft_reg_q    <= '0;
      rht_reg_q    <= '0;
    end else begin
      strt_cnv_q   <= 1'b0;
      cycle_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          accum_q <= '0;
          k_q     <= '0;
          cnt_q   <= '0;
          // A timed-out loop parks here until go is dropped
          if (!a2d_err_q) begin
            ir_en_q <= IR_FIRST;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_q      <= '0;
            strt_cnv_q <= 1'b1;
            chnnl_q    <= {k_q, 1'b0};
            state_q    <= WAIT_R;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        WAIT_R: begin
          if (cnv_cmplt) begin
            accum_q <= acc_add;
            cnt_q   <= '0;
            state_q <= GAP;
          end else if (cnt_q == TIMEOUT_LAST) begin
            a2d_err_q <= 1'b1;
            ir_en_q   <= '0;
            cnt_q     <= '0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q      <= '0;
            strt_cnv_q <= 1'b1;
            chnnl_q    <= {k_q, 1'b1};
            state_q    <= WAIT_L;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        WAIT_L: begin
          if (cnv_cmplt) begin
            accum_q <= acc_sub;
            cnt_q   <= '0;
            state_q <= NEXT;
          end else if (cnt_q == TIMEOUT_LAST) begin
            a2d_err_q <= 1'b1;
            ir_en_q   <= '0;
            cnt_q     <= '0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        NEXT: begin
          // Emitter hands straight over to the next pair so IR_en never glitches to zero mid-scan
          if (k_q == LAST_K) begin
            error_q <= sat12(27'(accum_q));
            ir_en_q <= '0;
            state_q <= INTG;
          end else begin
            k_q     <= k_q + 2'd1;
            ir_en_q <= ir_en_q << 1;
            state_q <= SETTLE;
          end
        end
        INTG: begin
          fwd_q <= fwd_nxt;
          if (int_cnt_inc == 8'(INT_DEC)) begin
            intgrl_q  <= sat12(27'(intg_sum));
            int_cnt_q <= '0;
          end else begin
            int_cnt_q <= int_cnt_inc;
          end
          state_q <= ICMP;
        end
        ICMP: begin
          icomp_q <= sat16(27'(ishift));
          state_q <= PCMP;
        end
        PCMP: begin
          pcomp_q <= sat16(pshift);
          state_q <= MOTOR;
        end
        MOTOR: begin
          rht_reg_q    <= sat12(27'(rht_sum));
          lft_reg_q    <= sat12(27'(lft_sum));
          cycle_done_q <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign strt_cnv   = strt_cnv_q;
  assign chnnl      = chnnl_q;
  assign IR_en      = ir_en_q;
  assign cycle_done = cycle_done_q;
  assign a2d_err    = a2d_err_q;
  assign lft        = 11'(lft_reg_q >> 1);
  assign rht        = 11'(rht_reg_q >> 1);
  assign LEDs       = 8'(error_q >> 4);

endmodule

// File: tb/tb_line_pi_ctrl.sv
// tb/tb_line_pi_ctrl.sv - self-checking bench for line_pi_ctrl
module tb_line_pi_ctrl;

  localparam int NP     = 3;
  localparam int SETTLE = 16;
  localparam int GAP    = 4;
  localparam int TMO    = 40;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            go = 1'b0;
  logic            cnv_cmplt = 1'b0;
  logic [11:0]     A2D_res = '0;
  logic [13:0]     Pterm = '0;
  logic [11:0]     Iterm = '0;
  logic            strt_cnv;
  logic [2:0]      chnnl;
  logic [NP-1:0]   IR_en;
  logic [10:0]     lft;
  logic [10:0]     rht;
  logic [7:0]      LEDs;
  logic            cycle_done;
  logic            a2d_err;

  line_pi_ctrl #(
    .NUM_PAIRS(NP), .SETTLE_CYC(SETTLE), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .strt_cnv(strt_cnv), .chnnl(chnnl),
    .cnv_cmplt(cnv_cmplt), .A2D_res(A2D_res), .Pterm(Pterm), .Iterm(Iterm),
    .IR_en(IR_en), .lft(lft), .rht(rht), .LEDs(LEDs), .cycle_done(cycle_done),
    .a2d_err(a2d_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] r;
    logic [11:0] l;
    logic [13:0] pterm;
    logic [11:0] iterm;
    int          ncyc;
    logic [10:0] exp_lft;
    logic [10:0] exp_rht;
    logic [7:0]  exp_leds;
  } vec_t;

  typedef struct {
    logic [10:0] lft;
    logic [10:0] rht;
    logic [7:0]  leds;
  } exp_t;

  exp_t          exp_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            strt_cnt = 0;
  logic [2:0]    strt_ch[$];
  logic [NP-1:0] strt_ir[$];
  int            lat = 3;
  int            hold_ch = 8;
  logic [11:0]   res_r = '0;
  logic [11:0]   res_l = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint sat(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Reference model: constant sensor readings, cycles 1..ncyc from a cleared loop
  task automatic model_push(input vec_t v);
    longint e, p, i, fwd, intg, rr, ll;
    int icnt;
    exp_t x;
    e = 0; fwd = 0; intg = 0; icnt = 0;
    for (int k = 0; k < NP; k++) e += (longint'(v.r) - longint'(v.l)) * (longint'(1) << k);
    e = sat(e, -2048, 2047);
    p = (e * longint'(v.pterm)) >>> 12;
    for (int c = 1; c <= v.ncyc; c++) begin
      fwd = (fwd + 8 > 896) ? 896 : fwd + 8;
      icnt++;
      if (icnt == 4) begin
        intg = sat(intg + e, -2048, 2047);
        icnt = 0;
      end
      i = (intg * longint'(v.iterm)) >>> 12;
      rr = sat(fwd - p - i, -2048, 2047);
      ll = sat(fwd + p + i, -2048, 2047);
      x.lft  = 11'(ll >>> 1);
      x.rht  = 11'(rr >>> 1);
      x.leds = 8'(e >>> 4);
      exp_q.push_back(x);
    end
  endtask

  // A2D converter model: answers strt_cnv after lat cycles unless the channel is withheld
  initial begin
    int  wcnt;
    int  wch;
    bit  busy;
    busy = 0; wcnt = 0; wch = 0;
    forever begin
      @(negedge clk);
      cnv_cmplt = 1'b0;
      if (strt_cnv === 1'b1) begin
        busy = 1; wcnt = lat; wch = int'(chnnl);
      end else if (busy) begin
        if (wcnt > 1) wcnt--;
        else begin
          busy = 0;
          if (wch != hold_ch) begin
            cnv_cmplt = 1'b1;
            A2D_res   = wch[0] ? res_l : res_r;
          end
        end
      end
    end
  end

  // Output monitor: logs conversions and scores every cycle_done against the queue
  initial begin
    forever begin
      @(negedge clk);
      if (strt_cnv === 1'b1) begin
        strt_cnt++;
        strt_ch.push_back(chnnl);
        strt_ir.push_back(IR_en);
      end
      if (cycle_done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb_unexpected: cycle_done with empty queue lft=0x%0h rht=0x%0h", lft, rht);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_lft", lft, e.lft);
          check("sb_rht", rht, e.rht);
          check("sb_leds", LEDs, e.leds);
        end
      end
    end
  end

  task automatic go_low();
    @(negedge clk);
    go = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cycle_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_cycle_done: no pulse within %0d cycles", budget);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    vec_t base;
    logic ok;
    int   n, c0, c1, n0;

    tbl[0] = '{12'h100, 12'h080, 14'h0000, 12'h000,   1, 11'h004, 11'h004, 8'h38};
    tbl[1] = '{12'hFFF, 12'h000, 14'h3680, 12'h000,   1, 11'h3FF, 11'h400, 8'h7F};
    tbl[2] = '{12'h100, 12'h080, 14'h0000, 12'h500,   4, 11'h09C, 11'h784, 8'h38};
    tbl[3] = '{12'h000, 12'h200, 14'h1000, 12'h000,   2, 11'h408, 11'h3FF, 8'h80};
    tbl[4] = '{12'h010, 12'h020, 14'h2000, 12'h800,   4, 11'h784, 11'h09C, 8'hF9};
    tbl[5] = '{12'h000, 12'h001, 14'h0800, 12'h000,   1, 11'h002, 11'h006, 8'hFF};
    tbl[6] = '{12'h100, 12'h080, 14'h0000, 12'h000, 114, 11'h1C0, 11'h1C0, 8'h38};
    base   = tbl[0];

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_strt_cnv", strt_cnv, 0);
    check("rst_chnnl", chnnl, 0);
    check("rst_ir_en", IR_en, 0);
    check("rst_lft", lft, 0);
    check("rst_rht", rht, 0);
    check("rst_leds", LEDs, 0);
    check("rst_cycle_done", cycle_done, 0);
    check("rst_a2d_err", a2d_err, 0);
    rst_n = 1'b1;

    // Table-driven vectors, each from a cleared loop
    for (int t = 0; t < 7; t++) begin
      go_low();
      res_r = tbl[t].r; res_l = tbl[t].l; Pterm = tbl[t].pterm; Iterm = tbl[t].iterm;
      model_push(tbl[t]);
      go = 1'b1;
      for (int c = 0; c < tbl[t].ncyc; c++) begin
        wait_done(400, ok);
        if (!ok) break;
      end
      check($sformatf("vec%0d_lft", t), lft, tbl[t].exp_lft);
      check($sformatf("vec%0d_rht", t), rht, tbl[t].exp_rht);
      check($sformatf("vec%0d_leds", t), LEDs, tbl[t].exp_leds);
      check($sformatf("vec%0d_sb_drained", t), exp_q.size(), 0);
      exp_q.delete();
    end

    // Sequencing with a slow converter
    go_low();
    lat = 10; res_r = base.r; res_l = base.l; Pterm = '0; Iterm = '0;
    strt_ch.delete(); strt_ir.delete(); strt_cnt = 0;
    model_push(base);
    go = 1'b1;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      n++;
      if (strt_cnv === 1'b1) break;
    end
    check("seq_first_strt_latency", n, SETTLE + 1);
    check("seq_first_ir_en", IR_en, 1);
    wait_done(600, ok);
    check("seq_strt_count", strt_cnt, 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("seq_chnnl%0d", i), (strt_ch.size() > i) ? int'(strt_ch[i]) : -1, i);
      check($sformatf("seq_ir_en%0d", i), (strt_ir.size() > i) ? int'(strt_ir[i]) : -1, 1 << (i / 2));
    end
    check("seq_ir_en_after", IR_en, 0);

    // Conversion timeout on channel 2
    go_low();
    lat = 3; hold_ch = 2;
    go = 1'b1;
    c0 = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (strt_cnv === 1'b1 && chnnl == 3'd2) begin
        c0 = cyc;
        break;
      end
    end
    check("tmo_ch2_started", c0 >= 0, 1);
    c1 = -1;
    for (int i = 0; i < TMO + 20; i++) begin
      @(negedge clk);
      if (a2d_err === 1'b1) begin
        c1 = cyc;
        break;
      end
    end
    check("tmo_latency", c1 - c0, TMO);
    check("tmo_ir_en", IR_en, 0);
    n0 = strt_cnt;
    repeat (60) @(negedge clk);
    check("tmo_no_strt", strt_cnt - n0, 0);
    check("tmo_err_sticky", a2d_err, 1);
    hold_ch = 8;
    go_low();
    check("tmo_err_cleared", a2d_err, 0);
    strt_ch.delete();
    model_push(base);
    go = 1'b1;
    wait_done(400, ok);
    check("tmo_restart_chnnl", (strt_ch.size() > 0) ? int'(strt_ch[0]) : -1, 0);

    // Abort during WAIT_L of pair 1
    go_low();
    lat = 10;
    model_push(base);
    go = 1'b1;
    wait_done(600, ok);
    check("abt_pre_lft", lft, 11'h004);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (strt_cnv === 1'b1 && chnnl == 3'd3) begin
        ok = 1'b1;
        break;
      end
    end
    check("abt_ch3_started", ok, 1);
    repeat (3) @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    check("abt_ir_en", IR_en, 0);
    check("abt_lft", lft, 0);
    check("abt_rht", rht, 0);
    check("abt_leds", LEDs, 0);
    check("abt_chnnl", chnnl, 0);
    check("abt_strt_cnv", strt_cnv, 0);
    n0 = strt_cnt;
    repeat (20) @(negedge clk);
    check("abt_late_no_strt", strt_cnt - n0, 0);
    check("abt_late_lft", lft, 0);
    check("abt_late_err", a2d_err, 0);
    strt_ch.delete();
    model_push(base);
    go = 1'b1;
    wait_done(600, ok);
    check("abt_restart_chnnl", (strt_ch.size() > 0) ? int'(strt_ch[0]) : -1, 0);
    check("abt_restart_lft", lft, 11'h004);
    check("final_sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
